// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
// Contents: arbiter FSM state encoding, the latched request payload and the
// payload widths it is sized by.
package dmem_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned STRB_W     = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } arb_state_t;

    // Request fields captured at acceptance and replayed downstream
    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [STRB_W-1:0]     wstrb;
        logic                  lock;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Ports: req  - request vector
//        ptr  - highest-priority index this round
//        gnt  - one-hot grant (first set bit from ptr upward, wrapping)
//        idx  - binary index of gnt
//        any  - at least one request set
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   s;
    logic [IW-1:0] k;

    // Walk from ptr with wrap; ptr < N so one subtraction folds the wrap
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        s   = '0;
        k   = '0;
        for (int i = 0; i < int'(N); i++) begin
            s = {1'b0, ptr} + (IW+1)'(i);
            if (s >= (IW+1)'(N)) begin
                s = s - (IW+1)'(N);
            end
            k = s[IW-1:0];
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: round-robin share of one downstream memory port
// among NUM_REQ requesters, optional short-burst lock, one outstanding
// transaction, response routing and response timeout.
// Ports: clk/nreset (sync, active-low)
//        req_*   - per-requester packed request bus, req_ready acceptance pulse
//        rsp_*   - one-hot response pulse with shared error/read-data
//        m_*     - downstream request/response port
//        grant_idx - current or last granted requester
// ADDR_W/DATA_W may not exceed the dmem_pkg MEM_* payload widths.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ADDR_W   = MEM_ADDR_W,
    parameter int unsigned DATA_W   = MEM_DATA_W,
    parameter int unsigned LOCK_MAX = 8,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_we,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W/8-1:0]           m_wstrb,
    input  logic                          m_rvalid,
    input  logic [DATA_W-1:0]             m_rdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx
);

    localparam int unsigned SW  = DATA_W / 8;
    localparam int unsigned IW  = $clog2(NUM_REQ);
    localparam int unsigned LCW = $clog2(LOCK_MAX + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [IW-1:0]       lock_own_q, lock_own_d;
    logic                lock_vld_q, lock_vld_d;
    logic [LCW-1:0]      lock_cnt_q, lock_cnt_d;
    logic [TW-1:0]       wait_cnt_q, wait_cnt_d;
    mem_req_t            lat_q, lat_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                m_valid_q, m_valid_d;
    logic                done;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
    logic [SW-1:0]       wstrb_arr [NUM_REQ];

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                lock_hit;
    logic [IW-1:0]       sel_idx;

    // Split the packed request buses per requester
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        assign wstrb_arr[i] = req_wstrb[i*SW +: SW];
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A still-requesting lock owner bypasses round robin
    assign lock_hit = lock_vld_q && req_valid[lock_own_q];
    assign sel_idx  = lock_hit ? lock_own_q : pick_idx;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        lock_own_d  = lock_own_q;
        lock_vld_d  = lock_vld_q;
        lock_cnt_d  = lock_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        lat_d       = lat_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        m_valid_d   = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (lock_vld_q && !req_valid[lock_own_q]) begin
                    lock_vld_d = 1'b0;
                    lock_cnt_d = '0;
                end
                if (lock_hit || pick_any) begin
                    grant_d     = sel_idx;
                    lat_d.we    = req_we[sel_idx];
                    lat_d.addr  = MEM_ADDR_W'(addr_arr[sel_idx]);
                    lat_d.wdata = MEM_DATA_W'(wdata_arr[sel_idx]);
                    lat_d.wstrb = STRB_W'(wstrb_arr[sel_idx]);
                    lat_d.lock  = req_lock[sel_idx];
                    req_ready_d = lock_hit ? (NUM_REQ'(1) << lock_own_q) : pick_gnt;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // First ISSUE cycle raises m_valid; hold it until accepted
                if (m_valid_q && m_ready) begin
                    wait_cnt_d = '0;
                    state_d    = WAIT_RSP;
                end else begin
                    m_valid_d = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (m_rvalid) begin
                    done        = 1'b1;
                    rsp_rdata_d = lat_q.we ? '0 : m_rdata;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    done        = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion: respond, then either extend the lock or advance rr_ptr
        if (done) begin
            state_d     = IDLE;
            rsp_valid_d = NUM_REQ'(1) << grant_q;
            if (lat_q.lock && (lock_cnt_q < LCW'(LOCK_MAX - 1))) begin
                lock_vld_d = 1'b1;
                lock_own_d = grant_q;
                lock_cnt_d = lock_cnt_q + 1'b1;
            end else begin
                lock_vld_d = 1'b0;
                lock_cnt_d = '0;
                rr_ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            lock_own_q  <= '0;
            lock_vld_q  <= 1'b0;
            lock_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            lat_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            m_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            lock_own_q  <= lock_own_d;
            lock_vld_q  <= lock_vld_d;
            lock_cnt_q  <= lock_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            lat_q       <= lat_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            m_valid_q   <= m_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign m_valid   = m_valid_q;
    assign m_we      = lat_q.we;
    assign m_addr    = ADDR_W'(lat_q.addr);
    assign m_wdata   = DATA_W'(lat_q.wdata);
    assign m_wstrb   = SW'(lat_q.wstrb);
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (NUM_REQ=2, LOCK_MAX=3,
// TIMEOUT=5). Inputs change and outputs are sampled 1ns after each posedge.
module tb_dmem_arbiter;

    logic        clk;
    logic        nreset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [1:0]  req_lock;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        grant_idx;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(
        .NUM_REQ  (2),
        .ADDR_W   (32),
        .DATA_W   (32),
        .LOCK_MAX (3),
        .TIMEOUT  (5)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        tick();
        tick();
        chk("rst_ready_rsp", {req_ready, rsp_valid, rsp_err}, 5'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_mctl", {m_valid, m_we, m_wstrb, grant_idx}, 7'b0);
        chk("rst_maddr", m_addr, 32'h0);
        chk("rst_mwdata", m_wdata, 32'h0);
        nreset = 1'b1;
    endtask

    // Slave for held-valid traffic: accept, handshake at once, respond at once
    task automatic serve(input string tag, output int g);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (req_ready == 2'b00 && k < 20);
        chk({tag, "_accept"}, 64'(req_ready != 2'b00), 64'd1);
        g = req_ready[1] ? 1 : 0;
        m_ready = 1'b1;
        tick();
        tick();
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h0000_1000 + 32'(g);
        tick();
        m_rvalid = 1'b0;
        chk({tag, "_rsp"}, rsp_valid, 64'(2'b01 << g));
    endtask

    initial begin
        int g;
        nreset    = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        m_ready   = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;

        do_reset();

        // Single read by req0
        req_addr  = {32'h0, 32'h10};
        req_valid = 2'b01;
        tick();
        chk("rd_ready", req_ready, 2'b01);
        chk("rd_mvalid_early", m_valid, 1'b0);
        req_valid = 2'b00;
        m_ready   = 1'b1;
        tick();
        chk("rd_mvalid", m_valid, 1'b1);
        chk("rd_maddr", m_addr, 32'h10);
        chk("rd_mwe", m_we, 1'b0);
        chk("rd_ready_pulse", req_ready, 2'b00);
        tick();
        chk("rd_mvalid_drop", m_valid, 1'b0);
        m_ready = 1'b0;
        tick();
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEAD_BEEF;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        chk("rd_rsp", {rsp_valid, rsp_err}, 3'b010);
        chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
        tick();
        chk("rd_rsp_pulse", rsp_valid, 2'b00);
        chk("rd_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

        // Timeout on req1 read, then a late m_rvalid is dropped
        req_addr  = {32'h20, 32'h0};
        req_valid = 2'b10;
        tick();
        chk("to_ready", req_ready, 2'b10);
        req_valid = 2'b00;
        m_ready   = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_early%0d", i), rsp_valid, 2'b00);
        end
        tick();
        chk("to_rsp", {rsp_valid, rsp_err}, 3'b101);
        chk("to_rdata", rsp_rdata, 32'h0);
        tick();
        chk("to_rsp_pulse", rsp_valid, 2'b00);
        m_rvalid = 1'b1;
        m_rdata  = 32'hCAFE_F00D;
        tick();
        m_rvalid = 1'b0;
        tick();
        chk("to_late_rsp", {rsp_valid, m_valid}, 3'b000);
        chk("to_late_rdata", rsp_rdata, 32'h0);

        // Write with byte strobe by req1, slave stalls m_ready for 3 cycles
        req_addr  = {32'h44, 32'h0};
        req_wdata = {32'h0000_00AB, 32'h0};
        req_wstrb = 8'b0001_0000;
        req_we    = 2'b10;
        req_valid = 2'b10;
        tick();
        chk("wr_ready", req_ready, 2'b10);
        req_valid = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("wr_ctl%0d", c), {m_valid, m_we, m_wstrb}, 6'b11_0001);
            chk($sformatf("wr_addr%0d", c), m_addr, 32'h44);
            chk($sformatf("wr_data%0d", c), m_wdata, 32'h0000_00AB);
        end
        m_ready = 1'b1;
        tick();
        chk("wr_mvalid_drop", m_valid, 1'b0);
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h1234_5678;
        tick();
        m_rvalid = 1'b0;
        chk("wr_rsp", {rsp_valid, rsp_err}, 3'b100);
        chk("wr_rdata_zero", rsp_rdata, 32'h0);
        req_we = 2'b00;

        // Reset during WAIT_RSP on a req1 read
        req_addr  = {32'h80, 32'h0};
        req_valid = 2'b10;
        tick();
        chk("ro_grant", {req_ready, grant_idx}, 3'b101);
        req_valid = 2'b00;
        m_ready   = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        nreset  = 1'b0;
        tick();
        chk("ro_after_rst", {m_valid, rsp_valid, req_ready, grant_idx}, 6'b0);
        nreset   = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h5555_5555;
        tick();
        m_rvalid = 1'b0;
        chk("ro_stale_rsp", rsp_valid, 2'b00);
        chk("ro_stale_rdata", rsp_rdata, 32'h0);
        req_valid = 2'b11;
        tick();
        chk("ro_first_grant", req_ready, 2'b01);
        req_valid = 2'b00;

        // Fairness: both held valid, no lock
        do_reset();
        req_addr  = {32'h200, 32'h100};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            serve($sformatf("fair%0d", i), g);
            chk($sformatf("fair%0d_grant", i), 64'(g), 64'(i % 2));
        end
        req_valid = 2'b00;

        // Lock cap: req0 locked for LOCK_MAX=3 grants, then req1, then req0
        do_reset();
        req_lock  = 2'b01;
        req_valid = 2'b11;
        begin
            int exp_lock [5] = '{0, 0, 0, 1, 0};
            for (int i = 0; i < 5; i++) begin
                serve($sformatf("lock%0d", i), g);
                chk($sformatf("lock%0d_grant", i), 64'(g), 64'(exp_lock[i]));
            end
        end
        req_valid = 2'b00;
        req_lock  = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (umem / AXI master side) between up to NUM_REQ requesters: CPU load/store port, ADC handoff DMA and sine-driver table fetch.
- Round-robin arbitration with optional bus lock for short bursts.
- One outstanding transaction at a time.
- Issues the latched request downstream, waits for the response and routes it back to the granted requester. A response timeout guards against a hung slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- LOCK_MAX, 8, max consecutive locked grants to one requester before forced release.
- TIMEOUT, 255, cycles to wait for m_rvalid before an error response.

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- req_we  in  NUM_REQ  1 = write
- req_lock  in  NUM_REQ  keep grant after this transfer
- req_addr  in  NUM_REQ*ADDR_W  packed addresses
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_wstrb  in  NUM_REQ*DATA_W/8  byte strobes (SB/SH/SW widths)
- rsp_valid  out  NUM_REQ  one-hot response pulse
- rsp_err  out  1  response error, qualified by rsp_valid
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- m_valid  out  1  downstream request valid
- m_ready  in  1  downstream accept
- m_we  out  1  downstream write
- m_addr  out  ADDR_W  downstream address
- m_wdata  out  DATA_W  downstream write data
- m_wstrb  out  DATA_W/8  downstream strobes
- m_rvalid  in  1  downstream response; m_rdata valid
- m_rdata  in  DATA_W  downstream read data
- grant_idx  out  $clog2(NUM_REQ)  current or last grant, for debug

Behaviour:
- Reset (nreset=0 at posedge): state IDLE; rr_ptr=0; lock_cnt=0; grant_idx=0. All outputs 0: req_ready, rsp_valid, rsp_err, rsp_rdata, m_valid, m_we, m_addr, m_wdata, m_wstrb.
  - Applies mid-transaction. An in-flight m_rvalid arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Exception: if locked_owner is valid and its req_valid=1, that owner wins regardless of rr_ptr.
  - Register grant_idx, we, addr, wdata, wstrb and lock.
  - Pulse req_ready[g] in the same cycle, registered as a one-cycle pulse coincident with the latch edge; go to ISSUE.
  - Requesters must hold valid and payload until req_ready; the arbiter ignores a drop before ready.
- ISSUE:
  - m_valid=1 with latched fields, held stable until m_ready=1 at a posedge; then m_valid=0 and go to WAIT_RSP.
  - Minimum request-to-m_valid latency: 1 cycle after acceptance.
- WAIT_RSP:
  - On m_rvalid: next cycle rsp_valid[g]=1 for 1 cycle, rsp_rdata=m_rdata (zero for writes), rsp_err=0; go to IDLE.
  - Writes also complete on m_rvalid.
- Timeout:
  - wait_cnt counts cycles in WAIT_RSP. On reaching TIMEOUT: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0; go to IDLE.
  - A late m_rvalid arriving in IDLE or ISSUE is discarded.
- Pointer/lock update on completion:
  - If latched lock=1 and lock_cnt<LOCK_MAX-1: locked_owner=g, lock_cnt++, rr_ptr unchanged.
  - Otherwise: locked_owner cleared, lock_cnt=0, rr_ptr=(g+1) mod NUM_REQ.
  - If the locked owner deasserts req_valid in IDLE, the lock is released and normal round robin resumes from rr_ptr.
- Back-to-back throughput: max 1 transaction per 4 cycles (IDLE, ISSUE, WAIT_RSP, response cycle overlaps next IDLE).
- rsp_rdata holds its last value between responses.
- grant_idx holds its last value.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef enum {IDLE, ISSUE, WAIT_RSP} arb_state_t
  - typedef struct mem_req_t {we, addr, wdata, wstrb, lock}
  - localparam STRB_W = DATA_W/8
- One sub-module, rr_pick: combinational round-robin priority picker (req vector, rr_ptr -> one-hot grant + index, any).

Test Plan:
- Single read: NUM_REQ=2; req0 read at 0x10; m_ready same cycle; m_rvalid 2 cycles later with m_rdata=0xDEADBEEF -> m_valid one cycle after req_ready[0]; rsp_valid=2'b01, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Fairness: req0 and req1 held valid continuously, 6 transfers, no lock -> grant order 0,1,0,1,0,1.
- Lock cap: LOCK_MAX=3; req0 with req_lock=1 and req1 both valid -> grants 0,0,0,1; rr_ptr=0 after the req1 grant.
- Timeout: TIMEOUT=5; slave never asserts m_rvalid -> rsp_valid[g] with rsp_err=1 exactly 5 cycles into WAIT_RSP. A later m_rvalid pulse produces no response.
- Write with strobe: req1 write addr 0x44, wdata 0x000000AB, wstrb 4'b0001; m_ready held low 3 cycles -> m_* fields stable for all 4 cycles of m_valid; then rsp_valid=2'b10.
- Reset mid-op: nreset=0 during WAIT_RSP -> next cycle m_valid=0, state IDLE, rsp_valid=0. m_rvalid after reset release is ignored; req0 is granted first afterwards.
